// File: rtl/distance_averager.sv
`default_nettype none
// ============================================================================
// Module   : distance_averager
// Purpose  : Sliding-window averager for 12-bit distance samples. It averages
//            the most recent 2**LOG2_N accepted samples using a circular
//            buffer and a running sum. The registered average feeds the
//            intensity mapping stage, where 0xFFF means "farthest" (minimum
//            intensity). That is why the idle and warm-up value is all ones.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   LOG2_N       log2 of window length, N = 2**LOG2_N (legal 1..6)
//   W            sample / average width in bits
// Ports
//   clk          in   1  system clock, rising edge
//   reset_n      in   1  asynchronous reset, active low
//   sample       in   W  new distance sample, qualified by sample_valid
//   sample_valid in   1  accept strobe, back-to-back allowed
//   flush        in   1  synchronous clear of the window (wins over accept)
//   average      out  W  registered window average (floor)
//   avg_valid    out  1  one-cycle pulse per accepted sample once filled
//   filled       out  1  N samples accepted since reset/flush
// ============================================================================
module distance_averager #(
    parameter int LOG2_N = 3,
    parameter int W      = 12
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] sample,
    input  logic         sample_valid,
    input  logic         flush,
    output logic [W-1:0] average,
    output logic         avg_valid,
    output logic         filled
);

    localparam int N  = 1 << LOG2_N;
    // N * (2**W - 1) always fits in W + LOG2_N bits, so the sum never wraps.
    localparam int SW = W + LOG2_N;
    // The count must be able to hold the value N itself.
    localparam int CW = LOG2_N + 1;

    localparam logic [CW-1:0] N_CNT    = CW'(N);
    localparam logic [W-1:0]  AVG_IDLE = '1;

    // Window storage. It is deliberately not reset: entries are only read
    // back once the window is full, and by then every slot has been rewritten.
    logic [W-1:0]      win_q [N];

    logic [LOG2_N-1:0] wptr_q,      wptr_d;
    logic [CW-1:0]     count_q,     count_d;
    logic [SW-1:0]     sum_q,       sum_d;
    logic              filled_q,    filled_d;
    logic              pending_q,   pending_d;
    logic [W-1:0]      average_q,   average_d;
    logic              avg_valid_q, avg_valid_d;

    logic              accept_w;
    logic [W-1:0]      old_w;

    // flush drops a coincident sample.
    assign accept_w = sample_valid & ~flush;

    // Before the window is full, the slot being overwritten holds nothing
    // that belongs to the running sum.
    assign old_w = filled_q ? win_q[wptr_q] : '0;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wptr_d      = wptr_q;
        count_d     = count_q;
        sum_d       = sum_q;
        filled_d    = filled_q;
        pending_d   = 1'b0;
        average_d   = average_q;
        avg_valid_d = 1'b0;

        if (flush) begin
            wptr_d      = '0;
            count_d     = '0;
            sum_d       = '0;
            filled_d    = 1'b0;
            pending_d   = 1'b0;
            average_d   = AVG_IDLE;
            avg_valid_d = 1'b0;
        end else begin
            // Output stage. It works on the sum registered by the previous
            // accept, so it runs independently of this cycle's accept.
            // During warm-up the average keeps its idle value.
            if (pending_q && filled_q) begin
                average_d   = sum_q[SW-1:LOG2_N];
                avg_valid_d = 1'b1;
            end

            if (accept_w) begin
                // The sum stays non-negative, because old_w is already
                // part of it.
                sum_d     = sum_q + SW'(sample) - SW'(old_w);
                wptr_d    = wptr_q + 1'b1;
                count_d   = (count_q == N_CNT) ? count_q : count_q + 1'b1;
                filled_d  = filled_q | (count_q == N_CNT - 1'b1);
                pending_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q      <= '0;
            count_q     <= '0;
            sum_q       <= '0;
            filled_q    <= 1'b0;
            pending_q   <= 1'b0;
            average_q   <= AVG_IDLE;
            avg_valid_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            filled_q    <= filled_d;
            pending_q   <= pending_d;
            average_q   <= average_d;
            avg_valid_q <= avg_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept_w) begin
            win_q[wptr_q] <= sample;
        end
    end

    assign average   = average_q;
    assign avg_valid = avg_valid_q;
    assign filled    = filled_q;

endmodule
`default_nettype wire

// File: tb/tb_distance_averager.sv
`default_nettype none
// ============================================================================
// Module   : tb_distance_averager
// Purpose  : Self-checking bench for distance_averager (LOG2_N=3, W=12).
// Revision : 1.0 - initial release
// ============================================================================
module tb_distance_averager;

    localparam int LOG2_N = 3;
    localparam int W      = 12;
    localparam int N      = 1 << LOG2_N;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] sample;
    logic         sample_valid;
    logic         flush;
    logic [W-1:0] average;
    logic         avg_valid;
    logic         filled;

    int checks   = 0;
    int failures = 0;

    distance_averager #(.LOG2_N(LOG2_N), .W(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample       (sample),
        .sample_valid (sample_valid),
        .flush        (flush),
        .average      (average),
        .avg_valid    (avg_valid),
        .filled       (filled)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: queue of the window's samples -------
    logic [W-1:0] mq[$];
    logic [W-1:0] m_avg;
    logic         m_av;
    logic         m_fil;
    logic         m_pend;

    task automatic model_clear();
        mq.delete();
        m_avg  = 12'hFFF;
        m_av   = 1'b0;
        m_fil  = 1'b0;
        m_pend = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic f, input logic [W-1:0] s);
        int unsigned total;
        if (f) begin
            model_clear();
        end else begin
            m_av = 1'b0;
            if (m_pend && mq.size() == N) begin
                total = 0;
                foreach (mq[k]) total += mq[k];
                m_avg = W'(total / N);
                m_av  = 1'b1;
            end
            if (v) begin
                mq.push_back(s);
                if (mq.size() > N) void'(mq.pop_front());
                m_pend = 1'b1;
            end else begin
                m_pend = 1'b0;
            end
            m_fil = (mq.size() == N);
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One clock: drive inputs away from the edge, sample 1 ns after it.
    task automatic cycle(input logic v, input logic f, input logic [W-1:0] s);
        sample_valid = v;
        flush        = f;
        sample       = s;
        @(posedge clk);
        #1;
        model_step(v, f, s);
        sample_valid = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic model_cmp(input string tag);
        chk({tag, "_avg"},    32'(average),   32'(m_avg));
        chk({tag, "_av"},     32'(avg_valid), 32'(m_av));
        chk({tag, "_filled"}, 32'(filled),    32'(m_fil));
    endtask

    // Reset asserted between clock edges; the outputs must clear at once.
    task automatic async_reset(input string tag);
        reset_n = 1'b0;
        #2;
        chk({tag, "_avg"},    32'(average),   32'hFFF);
        chk({tag, "_av"},     32'(avg_valid), 32'h0);
        chk({tag, "_filled"}, 32'(filled),    32'h0);
        model_clear();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic         v;
        logic         f;
        logic [W-1:0] s;
        logic         e_av;
        logic [W-1:0] e_avg;
        logic         e_fil;
    } vec_t;

    function automatic vec_t mk(logic v, logic f, logic [W-1:0] s,
                                logic e_av, logic [W-1:0] e_avg, logic e_fil);
        vec_t r;
        r.v = v; r.f = f; r.s = s; r.e_av = e_av; r.e_avg = e_avg; r.e_fil = e_fil;
        return r;
    endfunction

    vec_t tbl[18];

    initial begin
        int pulses;
        int gap;
        logic [W-1:0] rs;

        // Warm-up with 0x400; the expected outputs are those seen after each row's edge.
        tbl[0]  = mk(1, 0, 12'h400, 0, 12'hFFF, 0);
        tbl[1]  = mk(1, 0, 12'h400, 0, 12'hFFF, 0);
        tbl[2]  = mk(1, 0, 12'h400, 0, 12'hFFF, 0);
        tbl[3]  = mk(1, 0, 12'h400, 0, 12'hFFF, 0);
        tbl[4]  = mk(1, 0, 12'h400, 0, 12'hFFF, 0);
        tbl[5]  = mk(1, 0, 12'h400, 0, 12'hFFF, 0);
        tbl[6]  = mk(1, 0, 12'h400, 0, 12'hFFF, 0);
        tbl[7]  = mk(1, 0, 12'h400, 0, 12'hFFF, 1);
        // Slide in 0x800; each average trails its accept by one edge.
        tbl[8]  = mk(1, 0, 12'h800, 1, 12'h400, 1);
        tbl[9]  = mk(1, 0, 12'h800, 1, 12'h480, 1);
        tbl[10] = mk(1, 0, 12'h800, 1, 12'h500, 1);
        tbl[11] = mk(1, 0, 12'h800, 1, 12'h580, 1);
        tbl[12] = mk(1, 0, 12'h800, 1, 12'h600, 1);
        tbl[13] = mk(1, 0, 12'h800, 1, 12'h680, 1);
        tbl[14] = mk(1, 0, 12'h800, 1, 12'h700, 1);
        tbl[15] = mk(1, 0, 12'h800, 1, 12'h780, 1);
        tbl[16] = mk(0, 0, 12'h000, 1, 12'h800, 1);
        tbl[17] = mk(0, 0, 12'h000, 0, 12'h800, 1);

        reset_n      = 1'b0;
        sample       = '0;
        sample_valid = 1'b0;
        flush        = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("rst_avg",    32'(average),   32'hFFF);
        chk("rst_av",     32'(avg_valid), 32'h0);
        chk("rst_filled", 32'(filled),    32'h0);

        // ---- table: warm-up and sliding window ----
        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].v, tbl[i].f, tbl[i].s);
            chk($sformatf("tbl%0d_av", i),     32'(avg_valid), 32'(tbl[i].e_av));
            chk($sformatf("tbl%0d_avg", i),    32'(average),   32'(tbl[i].e_avg));
            chk($sformatf("tbl%0d_filled", i), 32'(filled),    32'(tbl[i].e_fil));
        end

        // ---- asynchronous reset mid-window, while a pulse is visible ----
        cycle(1, 0, 12'h300);
        cycle(1, 0, 12'h300);
        chk("prerst_av", 32'(avg_valid), 32'h1);
        async_reset("midrst");
        cycle(1, 0, 12'h123);
        chk("postrst_filled", 32'(filled), 32'h0);

        // ---- floor: seven 0x009 plus one 0x000 -> 63/8 = 7 ----
        cycle(0, 1, 12'h000);
        for (int i = 0; i < 7; i++) cycle(1, 0, 12'h009);
        cycle(1, 0, 12'h000);
        chk("floor_filled", 32'(filled), 32'h1);
        chk("floor_av0",    32'(avg_valid), 32'h0);
        cycle(0, 0, 12'h000);
        chk("floor_av",  32'(avg_valid), 32'h1);
        chk("floor_avg", 32'(average),   32'h007);

        // ---- full scale: eight 0xFFF, no wrap ----
        cycle(0, 1, 12'h000);
        for (int i = 0; i < 8; i++) cycle(1, 0, 12'hFFF);
        chk("max_sum", 32'(dut.sum_q), 32'h7FF8);
        cycle(0, 0, 12'h000);
        chk("max_av",  32'(avg_valid), 32'h1);
        chk("max_avg", 32'(average),   32'hFFF);

        // ---- flush collision, with a pending output in flight ----
        cycle(0, 1, 12'h000);
        for (int i = 0; i < 8; i++) cycle(1, 0, 12'h300);
        cycle(0, 0, 12'h000);
        chk("col_pre_avg", 32'(average), 32'h300);
        cycle(1, 0, 12'h300);
        cycle(1, 1, 12'h100);
        chk("col_avg",    32'(average),   32'hFFF);
        chk("col_av",     32'(avg_valid), 32'h0);
        chk("col_filled", 32'(filled),    32'h0);
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, 12'h100);
            chk($sformatf("col_w%0d_av", i),     32'(avg_valid), 32'h0);
            chk($sformatf("col_w%0d_filled", i), 32'(filled),    32'(i == 7));
        end
        cycle(0, 0, 12'h000);
        chk("col_av_end",  32'(avg_valid), 32'h1);
        chk("col_avg_end", 32'(average),   32'h100);

        // ---- sparse input with random idle gaps ----
        cycle(0, 1, 12'h000);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) begin
                cycle(0, 0, 12'h000);
                if (avg_valid) pulses++;
                chk("sparse_idle_av", 32'(avg_valid), 32'h0);
            end
            cycle(1, 0, 12'h200);
            if (avg_valid) pulses++;
            chk("sparse_acc_av", 32'(avg_valid), 32'h0);
        end
        cycle(0, 0, 12'h000);
        if (avg_valid) pulses++;
        chk("sparse_av",  32'(avg_valid), 32'h1);
        chk("sparse_avg", 32'(average),   32'h200);
        for (int g = 0; g < 4; g++) begin
            cycle(0, 0, 12'h000);
            if (avg_valid) pulses++;
        end
        chk("sparse_pulses", 32'(pulses), 32'h1);

        // ---- randomized traffic against the reference model ----
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       rs = 12'h000;
                1:       rs = 12'hFFF;
                default: rs = W'($urandom);
            endcase
            if (i == 1500) begin
                async_reset("rnd_rst");
            end
            cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3, rs);
            model_cmp("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/distance_averager.md
Name: distance_averager

Overview:
- Sliding-window averager for the 12-bit distance samples from the ultrasonic/ADC front end.
- Averages the most recent 2^LOG2_N samples using a circular buffer and a running sum.
- Its 12-bit average output feeds the intensity mapping stage directly; that stage reads 0xFFF as farthest, which gives minimum intensity.
- Sits between the sample capture logic and intensity mapping.

Parameters:
- LOG2_N, 3, log2 of window length; N = 2^LOG2_N samples (legal range 1..6).
- W, 12, sample and average width in bits.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- reset_n  input  1  asynchronous reset, active-low.
- sample  input  W  new distance sample; meaningful only when sample_valid=1.
- sample_valid  input  1  one-cycle strobe; sample is accepted on every rising edge where this is high (back-to-back cycles allowed).
- flush  input  1  synchronous clear of the window.
- average  output  W  registered window average.
- avg_valid  output  1  one-cycle pulse; a new average is present.
- filled  output  1  high once N samples have been accepted since reset or flush.

Behaviour:
- Reset (reset_n low, asynchronous):
  - sum=0, wptr=0, count=0, filled=0.
  - average=all ones (0xFFF), avg_valid=0.
  - Buffer contents need not be reset; they are don't-care while filled=0.
- State:
  - buf[N] of W bits.
  - wptr: LOG2_N bits; wraps N-1 -> 0 naturally.
  - count: saturates at N.
  - sum: W+LOG2_N bits. This width cannot overflow, since N*0xFFF fits.
- Accept (edge with sample_valid=1, flush=0):
  - old = filled ? buf[wptr] : 0.
  - sum <= sum + sample - old.
  - buf[wptr] <= sample; wptr <= wptr+1.
  - count <= count+1 (saturating).
  - filled <= 1 when count reaches N, i.e. after the Nth accept.
  - pending <= 1.
- Output stage (edge following an accept):
  - average <= sum >> LOG2_N (floor, truncating).
  - avg_valid <= filled.
  - Net latency: sample present in cycle c -> average/avg_valid visible after edge c+1.
  - With back-to-back samples, avg_valid stays high on consecutive cycles, one pulse per accepted sample.
- Warm-up (filled=0):
  - No avg_valid pulses and average holds its value (0xFFF after reset/flush), so downstream reports the least intense level.
  - The first avg_valid follows the Nth accepted sample.
- Idle (no sample_valid): average holds its value; avg_valid=0.
- flush=1 (synchronous):
  - Same clear as reset, including average=0xFFF.
  - The in-flight pending output is cancelled.
  - flush has priority over a simultaneous sample_valid; that sample is dropped.
- Asynchronous reset mid-window: all state is cleared immediately and warm-up restarts.
- Gaps between samples of any length are legal; the window counts samples, not cycles.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: assert reset_n=0 mid-clock -> average=0xFFF, avg_valid=0, filled=0 immediately, without waiting for a clock edge.
- Warm-up: 8 back-to-back samples of 0x400 -> no avg_valid for samples 1-7; filled rises after the 8th accept; one cycle later avg_valid=1, average=0x400.
- Sliding window: after the warm-up above, 8 back-to-back samples of 0x800 -> avg_valid high for 8 consecutive cycles, average = 0x480, 0x500, 0x580, 0x600, 0x680, 0x700, 0x780, 0x800.
- Arithmetic edges:
  - Seven samples of 0x009 plus one 0x000 -> average=0x007 (floor of 63/8).
  - Eight samples of 0xFFF -> average=0xFFF, sum=0x7FF8, no wrap.
- Flush collision: window filled with 0x300; assert flush and sample_valid (0x100) in the same cycle -> sample dropped, average=0xFFF, filled=0; the next 8 samples of 0x100 are required before avg_valid, then average=0x100.
- Sparse input: 8 samples of 0x200 separated by 0-5 idle cycles, randomized -> exactly one avg_valid, one cycle after the 8th accept, average=0x200; no avg_valid during idle cycles.
